cp0_int_request: RTL and testbench
==================================

// Module: cp0_int_request
// PURPOSE
// - Read-side companion of the write-back CP0 update: samples ext_int and CP0 Status/Cause, decides when an interrupt must be raised.
// - Tags the interrupt onto one in-flight instruction by handshake; tracks it until write-back commits the exception.
// - Drives Cause.IP[7:2] hardware bits back toward the CP0 update path.
// - Sits beside the decode stage; its tag becomes exception.valid with code EX_INT (0) for that instruction.
// PARAMETERS
// - TIMEOUT  default 15  max cycles in WAIT before forcing IDLE; 1..255
// - CNT_W    default 8    width of wait counter; must hold TIMEOUT
// PORTS
// - clk           in   1  clock, rising edge
// - resetn        in   1  asynchronous active-low reset
// - ext_int       in   6  external interrupt lines, level, asynchronous to clk
// - status_ie     in   1  CP0 Status.IE
// - status_exl    in   1  CP0 Status.EXL
// - status_erl    in   1  CP0 Status.ERL
// - status_im     in   8  CP0 Status.IM[7:0]
// - cause_ip_sw   in   2  CP0 Cause.IP[1:0] (software interrupts)
// - cause_ti      in   1  CP0 Cause.TI
// - int_valid     out  1  interrupt offered for tagging
// - tag_ready     in   1  pipeline attached interrupt to a valid, non-squashed instruction this cycle
// - wb_exc_taken  in   1  write-back took an exception this cycle (any code)
// - wb_flush      in   1  write-back redirect (exception or ERET) this cycle
// - ip_hw         out  6  Cause.IP[7:2] = {ext_s[5]|cause_ti, ext_s[4:0]}
// - int_pending   out  1  combinational pending term, for debug/trace
// BEHAVIOUR
// - Reset: state=IDLE, int_valid=0, ip_hw=0, ext_s=0, wait counter=0. Takes effect immediately, any state.
// - ext_s: ext_int after input sampling stage(s) (see CONFIGURATION); ip_hw is a register fed from ext_s and cause_ti, so it updates 1 cycle after either changes.
// - pending = status_ie & !status_exl & !status_erl & |(status_im & {ip_hw, cause_ip_sw}).
// - FSM states IDLE, PEND, WAIT:
//   - IDLE: int_valid=0. If pending, go to PEND next cycle.
//   - PEND: int_valid=1 (registered). If tag_ready, go to WAIT and clear counter.
//     Else if !pending (line dropped or masked), go to IDLE; withdrawal is legal.
//   - WAIT: int_valid=0, counter increments each cycle, saturating.
//     - wb_exc_taken: go to IDLE (EXL now masks further requests).
//     - wb_flush without wb_exc_taken: go to IDLE; the tagged instruction was squashed, so re-evaluate.
//     - counter==TIMEOUT-1: go to IDLE.
// - Priority in PEND: tag_ready over !pending; a same-cycle ack always goes to WAIT.
// - Priority in WAIT: wb_exc_taken > wb_flush > timeout.
// - One tag per request. int_valid is never high in WAIT or IDLE; it is at most one cycle stale versus pending.
// - Pipeline contract: tag_ready is asserted only while int_valid=1. Tagging beyond that is ignored.
// - Latency:
//   - ext_int rise to ip_hw: 2 cycles without INT_SYNC_EN, 3 with.
//   - ip_hw to int_valid: 2 cycles (IDLE->PEND, then registered int_valid).
// - Software IP via mtc0 Cause: pending is seen the cycle after the CP0 update; no special path.
// CONFIGURATION
// - CP0_INT_SYNC_EN defined: ext_int goes through a two-flop synchronizer before ext_s (metastability-safe, +1 cycle).
// - CP0_INT_SYNC_EN undefined: single register stage; ext_int must already be clk-synchronous.
// - The FSM is identical in both builds; only input latency differs.
// TESTING
// - Reset: resetn=0 mid-WAIT with ext_int=6'h3f -> next sample int_valid=0, ip_hw=0, state IDLE; release -> normal sequencing resumes.
// - Basic: IE=1, EXL=0, IM=8'h04, ext_int[0] 0->1 at cycle 0 -> ip_hw=6'h01 at cycle 2 (3 with SYNC), int_valid=1 two cycles later; tag_ready=1 -> int_valid=0 next cycle; wb_exc_taken -> IDLE.
// - Mask: IM=8'h00 or EXL=1 or ERL=1 with ext_int=6'h3f -> int_valid stays 0 for 50 cycles; ip_hw=6'h3f.
// - Withdrawal: reach PEND, drop ext_int with no ack -> int_valid falls within 3 cycles (4 with SYNC); ack with pending drop same cycle -> WAIT.
// - Squash/timeout: in WAIT, wb_flush=1 with wb_exc_taken=0 -> IDLE then PEND again if still pending; no wb_* for 15 cycles -> IDLE at counter 14.
// - Timer/software: cause_ti=1, IM[7]=1 -> ip_hw[5]=1, request raised; cause_ip_sw=2'b10, IM[1]=1, ext_int=0 -> request raised.

Source files
------------

// File: rtl/cp0_int_request.sv
// cp0_int_request
// Read-side interrupt request logic for CP0. Samples the external interrupt
// lines and the CP0 Status/Cause fields, decides when an interrupt must be
// raised, offers it to the decode stage for tagging onto one instruction and
// tracks that instruction until write-back commits (or squashes) it.
// Also produces the hardware Cause.IP[7:2] bits for the CP0 update path.
//
// Build option: define CP0_INT_SYNC_EN to put ext_int through a two-flop
// synchronizer (asynchronous lines, +1 cycle latency). Without it a single
// register stage is used and ext_int must already be synchronous to clk.
module cp0_int_request #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] ext_int,
    input  logic       status_ie,
    input  logic       status_exl,
    input  logic       status_erl,
    input  logic [7:0] status_im,
    input  logic [1:0] cause_ip_sw,
    input  logic       cause_ti,
    output logic       int_valid,
    input  logic       tag_ready,
    input  logic       wb_exc_taken,
    input  logic       wb_flush,
    output logic [5:0] ip_hw,
    output logic       int_pending
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [5:0]       ext_s;
    logic [CNT_W-1:0] wait_cnt;
    logic             pending;
    logic             ack;

`ifdef CP0_INT_SYNC_EN
    logic [5:0] ext_meta;

    // Two-flop synchronizer: ext_meta may go metastable, ext_s is clean.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_meta <= '0;
            ext_s    <= '0;
        end else begin
            ext_meta <= ext_int;
            ext_s    <= ext_meta;
        end
    end
`else
    // Single sampling stage; lines are already synchronous to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ext_s <= '0;
        else         ext_s <= ext_int;
    end
`endif

    // Hardware Cause.IP[7:2]; the timer interrupt shares IP7 with ext_int[5].
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ip_hw <= '0;
        else         ip_hw <= {ext_s[5] | cause_ti, ext_s[4:0]};
    end

    // Request is live only when globally enabled, not in exception/error
    // level, and at least one unmasked IP bit is set.
    always_comb begin
        pending = status_ie & ~status_exl & ~status_erl
                & (|(status_im & {ip_hw, cause_ip_sw}));
    end

    assign int_pending = pending;

    // A tag only counts while the request is actually offered.
    assign ack = tag_ready & int_valid;

    // Next-state: ack beats withdrawal in PEND; exception beats flush beats
    // timeout in WAIT (all three lead to IDLE, EXL then masks re-requests).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pending) state_next = PEND;
            end
            PEND: begin
                if (ack)           state_next = WAIT;
                else if (!pending) state_next = IDLE;
            end
            WAIT: begin
                if (wb_exc_taken)            state_next = IDLE;
                else if (wb_flush)           state_next = IDLE;
                else if (wait_cnt == CNT_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // int_valid rises one cycle after entering PEND and drops on the same
    // edge that leaves PEND, so it is never high in IDLE or WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) int_valid <= 1'b0;
        else         int_valid <= (state == PEND) && (state_next == PEND);
    end

    // Wait counter: cleared on the tag handshake, saturating count in WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == PEND && ack) begin
            wait_cnt <= '0;
        end else if (state == WAIT && wait_cnt != {CNT_W{1'b1}}) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cp0_int_request.sv
// Bench for cp0_int_request: steady-state vector table through a scoreboard
// queue, then hand-written cycle-exact sequences for handshake, withdrawal,
// squash, timeout, reset and masking.
module tb_cp0_int_request;

`ifdef CP0_INT_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 2;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [5:0] ext_int = '0;
    logic       status_ie = 1'b0;
    logic       status_exl = 1'b0;
    logic       status_erl = 1'b0;
    logic [7:0] status_im = '0;
    logic [1:0] cause_ip_sw = '0;
    logic       cause_ti = 1'b0;
    logic       int_valid;
    logic       tag_ready = 1'b0;
    logic       wb_exc_taken = 1'b0;
    logic       wb_flush = 1'b0;
    logic [5:0] ip_hw;
    logic       int_pending;

    cp0_int_request #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn), .ext_int(ext_int),
        .status_ie(status_ie), .status_exl(status_exl), .status_erl(status_erl),
        .status_im(status_im), .cause_ip_sw(cause_ip_sw), .cause_ti(cause_ti),
        .int_valid(int_valid), .tag_ready(tag_ready),
        .wb_exc_taken(wb_exc_taken), .wb_flush(wb_flush),
        .ip_hw(ip_hw), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] ext;
        logic       ie, exl, erl;
        logic [7:0] im;
        logic [1:0] sw;
        logic       ti;
        logic       ev;
        logic [5:0] eip;
        logic       ep;
    } vec_t;

    typedef struct {
        logic       v;
        logic [5:0] ip;
        logic       p;
    } exp_t;

    vec_t tbl[12];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic exp);
        chk(name, {7'b0, int_valid}, {7'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;

        // ext, ie, exl, erl, im, sw, ti | int_valid, ip_hw, pending (steady state)
        tbl[0]  = '{6'h00, 1'b1, 1'b0, 1'b0, 8'hff, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0};
        tbl[1]  = '{6'h01, 1'b1, 1'b0, 1'b0, 8'h04, 2'b00, 1'b0, 1'b1, 6'h01, 1'b1};
        tbl[2]  = '{6'h3f, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 6'h3f, 1'b0};
        tbl[3]  = '{6'h3f, 1'b1, 1'b1, 1'b0, 8'hff, 2'b00, 1'b0, 1'b0, 6'h3f, 1'b0};
        tbl[4]  = '{6'h3f, 1'b1, 1'b0, 1'b1, 8'hff, 2'b00, 1'b0, 1'b0, 6'h3f, 1'b0};
        tbl[5]  = '{6'h3f, 1'b0, 1'b0, 1'b0, 8'hff, 2'b00, 1'b0, 1'b0, 6'h3f, 1'b0};
        tbl[6]  = '{6'h00, 1'b1, 1'b0, 1'b0, 8'h80, 2'b00, 1'b1, 1'b1, 6'h20, 1'b1};
        tbl[7]  = '{6'h00, 1'b1, 1'b0, 1'b0, 8'h02, 2'b10, 1'b0, 1'b1, 6'h00, 1'b1};
        tbl[8]  = '{6'h00, 1'b1, 1'b0, 1'b0, 8'h02, 2'b01, 1'b0, 1'b0, 6'h00, 1'b0};
        tbl[9]  = '{6'h20, 1'b1, 1'b0, 1'b0, 8'h80, 2'b00, 1'b0, 1'b1, 6'h20, 1'b1};
        tbl[10] = '{6'h10, 1'b1, 1'b0, 1'b0, 8'h80, 2'b00, 1'b0, 1'b0, 6'h10, 1'b0};
        tbl[11] = '{6'h10, 1'b1, 1'b0, 1'b0, 8'h40, 2'b00, 1'b0, 1'b1, 6'h10, 1'b1};

        // Reset state
        repeat (3) step();
        chk_v("reset_valid", 1'b0);
        chk("reset_ip_hw", {2'b0, ip_hw}, 8'h00);
        chk("reset_pending", {7'b0, int_pending}, 8'h00);
        resetn = 1'b1;

        // Steady-state table through the scoreboard
        for (int i = 0; i < 12; i++) begin
            ext_int = tbl[i].ext; status_ie = tbl[i].ie; status_exl = tbl[i].exl;
            status_erl = tbl[i].erl; status_im = tbl[i].im;
            cause_ip_sw = tbl[i].sw; cause_ti = tbl[i].ti;
            sb.push_back('{tbl[i].ev, tbl[i].eip, tbl[i].ep});
            repeat (8) step();
            e = sb.pop_front();
            chk($sformatf("vec%0d_valid", i), {7'b0, int_valid}, {7'b0, e.v});
            chk($sformatf("vec%0d_ip_hw", i), {2'b0, ip_hw}, {2'b0, e.ip});
            chk($sformatf("vec%0d_pending", i), {7'b0, int_pending}, {7'b0, e.p});
        end

        // Back to a quiet IDLE
        ext_int = 6'h00; status_im = 8'h04; status_ie = 1'b1;
        status_exl = 1'b0; status_erl = 1'b0; cause_ip_sw = 2'b00; cause_ti = 1'b0;
        repeat (8) step();

        // Basic latency: ext_int -> ip_hw in L cycles, -> int_valid 2 more
        ext_int = 6'h01;
        repeat (L - 1) step();
        chk("basic_ip_early", {2'b0, ip_hw}, 8'h00);
        step();
        chk("basic_ip_hw", {2'b0, ip_hw}, 8'h01);
        step();
        chk_v("basic_valid_early", 1'b0);
        step();
        chk_v("basic_valid", 1'b1);
        tag_ready = 1'b1;
        step();
        tag_ready = 1'b0;
        chk_v("basic_after_ack", 1'b0);
        // Exception commits -> IDLE, still pending so re-raised right away
        wb_exc_taken = 1'b1;
        step();
        wb_exc_taken = 1'b0;
        step();
        chk_v("exc_idle_pend", 1'b0);
        step();
        chk_v("exc_reraise", 1'b1);

        // Withdrawal without ack
        ext_int = 6'h00;
        repeat (L) step();
        chk_v("withdraw_still", 1'b1);
        step();
        chk_v("withdraw_drop", 1'b0);

        // Ack with same-cycle pending drop still goes to WAIT
        ext_int = 6'h01;
        repeat (L + 2) step();
        chk_v("reraise_valid", 1'b1);
        status_im = 8'h00; tag_ready = 1'b1;
        step();
        status_im = 8'h04; tag_ready = 1'b0;
        chk_v("ack_drop_valid", 1'b0);
        repeat (2) step();
        chk_v("ack_drop_in_wait", 1'b0);

        // Squash: flush without exception -> IDLE -> PEND again
        wb_flush = 1'b1;
        step();
        wb_flush = 1'b0;
        step();
        chk_v("squash_pend", 1'b0);
        step();
        chk_v("squash_reraise", 1'b1);

        // Timeout: WAIT lasts 15 cycles (counter 0..14)
        tag_ready = 1'b1;
        step();
        tag_ready = 1'b0;
        repeat (15) step();
        chk_v("timeout_k15", 1'b0);
        step();
        chk_v("timeout_k16", 1'b0);
        step();
        chk_v("timeout_reraise", 1'b1);

        // Asynchronous reset mid-WAIT
        ext_int = 6'h3f; status_im = 8'hff; tag_ready = 1'b1;
        step();
        tag_ready = 1'b0;
        step();
        resetn = 1'b0;
        #1;
        chk_v("rst_async_valid", 1'b0);
        chk("rst_async_ip_hw", {2'b0, ip_hw}, 8'h00);
        step();
        chk_v("rst_hold_valid", 1'b0);
        resetn = 1'b1;
        repeat (L - 1) step();
        chk("rst_ip_early", {2'b0, ip_hw}, 8'h00);
        step();
        chk("rst_ip_hw", {2'b0, ip_hw}, 8'h3f);
        step();
        chk_v("rst_pend", 1'b0);
        step();
        chk_v("rst_valid", 1'b1);

        // Mask: IM=0 with all lines high holds off the request
        status_im = 8'h00;
        step();
        for (int i = 0; i < 50; i++) begin
            step();
            chk_v("mask_valid", 1'b0);
        end
        chk("mask_ip_hw", {2'b0, ip_hw}, 8'h3f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
